// File: rtl/divider_taint_track.sv
// Multi-cycle restoring divider (2N-bit dividend / N-bit divisor) with optional
// per-bit taint propagation, compiled in only when DIV_TAINT_TRACK_EN is defined.
module divider_taint_track #(
  parameter int NUM_BITS = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2*NUM_BITS-1:0] dividend,
  input  logic [NUM_BITS-1:0]   divisor,
  input  logic                  start_t,
  input  logic [2*NUM_BITS-1:0] dividend_t,
  input  logic [NUM_BITS-1:0]   divisor_t,
  output logic [2*NUM_BITS-1:0] quotient,
  output logic [NUM_BITS-1:0]   remainder,
  output logic                  done,
  output logic [2*NUM_BITS-1:0] quotient_t,
  output logic [NUM_BITS-1:0]   remainder_t,
  output logic                  done_t
);

  localparam int QW    = 2 * NUM_BITS;
  localparam int CNT_W = (QW > 2) ? $clog2(QW) : 1;

  typedef enum logic [1:0] {IDLE, INIT, CALC, DONE} state_e;

  state_e               state_q, state_d;
  logic [QW-1:0]        dvd_q, dvd_d;
  logic [NUM_BITS-1:0]  dsr_q, dsr_d;
  logic [QW-1:0]        quo_q, quo_d;
  logic [NUM_BITS-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 done_q, done_d;

  // Partial remainder is always below the divisor, so N bits plus the
  // incoming dividend bit never overflow N+1 bits.
  logic [NUM_BITS:0]    part;
  logic                 part_ge;

  assign part    = {rem_q, dvd_q[QW-1]};
  assign part_ge = (part >= {1'b0, dsr_q});

`ifdef DIV_TAINT_TRACK_EN
  logic [QW-1:0]        dvdt_q, dvdt_d;
  logic [NUM_BITS-1:0]  dsrt_q, dsrt_d;
  logic [QW-1:0]        quot_q, quot_d;
  logic [NUM_BITS-1:0]  remt_q, remt_d;
  logic                 stt_q, stt_d;
  logic                 cmp_t;

  assign cmp_t = (|remt_q) | dvdt_q[QW-1] | (|dsrt_q);
`else
  logic unused_taint_inputs;
  assign unused_taint_inputs = ^{start_t, dividend_t, divisor_t};
`endif

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
`ifdef DIV_TAINT_TRACK_EN
    dvdt_d  = dvdt_q;
    dsrt_d  = dsrt_q;
    quot_d  = quot_q;
    remt_d  = remt_q;
    stt_d   = stt_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        // DONE also lets a divide-by-zero result raise done one cycle after entry.
        if (state_q == DONE) done_d = 1'b1;
        if (start) begin
          dvd_d   = dividend;
          dsr_d   = divisor;
          done_d  = 1'b0;
          state_d = INIT;
`ifdef DIV_TAINT_TRACK_EN
          dvdt_d  = dividend_t;
          dsrt_d  = divisor_t;
          stt_d   = start_t;
`endif
        end
      end
      INIT: begin
        if (dsr_q == '0) begin
          quo_d   = '1;
          rem_d   = dvd_q[NUM_BITS-1:0];
          state_d = DONE;
`ifdef DIV_TAINT_TRACK_EN
          quot_d  = {QW{|dsrt_q}};
          remt_d  = dvdt_q[NUM_BITS-1:0];
`endif
        end else begin
          quo_d   = '0;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
`ifdef DIV_TAINT_TRACK_EN
          quot_d  = '0;
          remt_d  = '0;
`endif
        end
      end
      CALC: begin
        quo_d = {quo_q[QW-2:0], part_ge};
        rem_d = part_ge ? NUM_BITS'(part - {1'b0, dsr_q}) : part[NUM_BITS-1:0];
        dvd_d = {dvd_q[QW-2:0], 1'b0};
        cnt_d = cnt_q + 1'b1;
`ifdef DIV_TAINT_TRACK_EN
        quot_d = {quot_q[QW-2:0], cmp_t};
        remt_d = {NUM_BITS{cmp_t}};
        dvdt_d = {dvdt_q[QW-2:0], 1'b0};
`endif
        if (cnt_q == CNT_W'(QW - 1)) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dsr_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = done_q;

`ifdef DIV_TAINT_TRACK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvdt_q <= '0;
      dsrt_q <= '0;
      quot_q <= '0;
      remt_q <= '0;
      stt_q  <= 1'b0;
    end else begin
      dvdt_q <= dvdt_d;
      dsrt_q <= dsrt_d;
      quot_q <= quot_d;
      remt_q <= remt_d;
      stt_q  <= stt_d;
    end
  end

  // A tainted request taints every result bit once the result is valid.
  assign done_t      = done_q & stt_q;
  assign quotient_t  = (done_q & stt_q) ? '1 : quot_q;
  assign remainder_t = (done_q & stt_q) ? '1 : remt_q;
`else
  assign done_t      = 1'b0;
  assign quotient_t  = '0;
  assign remainder_t = '0;
`endif

endmodule

// File: doc/divider_taint_track.md
DIVIDER_TAINT_TRACK -- requirements
Module: divider_taint_track

Interface
REQ-001 SHALL have parameter NUM_BITS, default 7: divisor width N; dividend and quotient are 2N bits wide.
REQ-002 SHALL have port clk, input, 1 bit: single clock, rising-edge.
REQ-003 SHALL have port rst, input, 1 bit: one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request a division.
REQ-005 SHALL have port dividend, input, 2N bits: unsigned dividend.
REQ-006 SHALL have port divisor, input, N bits: unsigned divisor.
REQ-007 SHALL have ports start_t (1 bit), dividend_t (2N bits) and divisor_t (N bits), all inputs: per-bit taint of the matching input.
REQ-008 SHALL have port quotient, output, 2N bits: result quotient.
REQ-009 SHALL have port remainder, output, N bits: result remainder.
REQ-010 SHALL have port done, output, 1 bit: result valid.
REQ-011 SHALL have ports quotient_t (2N bits), remainder_t (N bits) and done_t (1 bit), all outputs: taint of the matching output.

Function
REQ-012 SHALL implement a four-state FSM with states IDLE, INIT, CALC and DONE.
REQ-013 SHALL, in IDLE or DONE, on a rising edge with start=1: capture dividend, divisor, all taint inputs and start_t; clear done; go to INIT.
REQ-014 SHALL ignore start while in INIT or CALC.
REQ-015 SHALL, in INIT with captured divisor==0, go to DONE and set quotient=all ones and remainder=dividend[N-1:0]; done SHALL be high after the 2nd edge counted from the capture edge.
REQ-016 SHALL, in INIT with divisor!=0, clear the (N+1)-bit partial remainder, the quotient and the iteration counter, then go to CALC.
REQ-017 SHALL perform one restoring iteration per CALC cycle, MSB first: P={R, next dividend bit}; if P>=divisor then quotient bit=1 and R=P-divisor, else quotient bit=0 and R=P.
REQ-018 SHALL run exactly 2N CALC cycles and then enter DONE; done SHALL be high after the (2N+1)th edge counted from the capture edge (15 edges for N=7).
REQ-019 SHALL, in DONE, hold done=1 and keep quotient, remainder and all taint outputs stable until the next start.
REQ-020 SHALL keep the remainder output at N bits (R<divisor always holds); the arithmetic SHALL never overflow.
REQ-021 SHALL apply this per-iteration taint rule: cmp_t = OR(taint of P bits) OR OR(divisor_t); the quotient bit's taint = cmp_t; the taint of every bit of R = cmp_t.
REQ-022 SHALL, on a divide-by-zero, set quotient_t=all ones if any divisor_t bit is set, else 0; remainder_t SHALL equal dividend_t[N-1:0].
REQ-023 SHALL, when captured start_t=1, force done_t=1 and all quotient_t and remainder_t bits to 1 at DONE; otherwise done_t SHALL be 0.

Reset
REQ-024 SHALL, while rst=1, asynchronously force state=IDLE, quotient=0, remainder=0, done=0, all taint outputs=0, and clear all internal registers.
REQ-025 SHALL let rst take priority over start, and SHALL let rst abort INIT or CALC at any cycle with no result produced.
REQ-026 SHALL sample start on the first rising edge after rst deasserts.

Configuration
REQ-027 SHALL compile the taint logic only when macro DIV_TAINT_TRACK_EN is defined: with it, REQ-021 to REQ-023 apply; without it, taint inputs are ignored, taint outputs are tied to 0 and no taint registers exist; quotient, remainder and done behaviour and timing are identical in both cases.

Verification
REQ-028 SHALL cover: N=7, 225/15, no taint -> quotient=15, remainder=0, done after 15 edges, all taint outputs 0.
REQ-029 SHALL cover: 6900/92 -> 75 r0; 3277/42 -> 78 r1; 0/5 -> 0 r0.
REQ-030 SHALL cover: 12/0 -> quotient=16383, remainder=12, done after 2 edges; repeating with divisor_t=1 -> quotient_t=16383.
REQ-031 SHALL cover: 225/15 with dividend_t=1 -> quotient_t=1, remainder_t=127; with divisor_t=1 -> quotient_t=16383, remainder_t=127.
REQ-032 SHALL cover: start_t=1 on 6900/92 -> done_t=1, quotient_t=16383, remainder_t=127; DIV_TAINT_TRACK_EN undefined -> all taint outputs stay 0.
REQ-033 SHALL cover: rst asserted at CALC cycle 5 -> outputs 0 at once, state IDLE; a following 42/3 -> 14 r0 after 15 edges; a start pulse during CALC is ignored.
